// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a valid/ready load and per-bit ser_en flow control.
// Define PISO_PARITY_EN to append an even-parity bit (PAR state) after the WIDTH data bits.
module piso_serializer #(
    parameter int WIDTH     = 16,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             ser_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             busy
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    if (WIDTH < 2) begin : g_width_check
        $error("piso_serializer: WIDTH must be at least 2");
    end

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             data_bit;
    logic             load_acc;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    assign data_bit = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];

    // Outputs depend only on registers and ser_en, never on din or load_valid.
    always_comb begin
        busy       = (state_q != IDLE);
        sout_valid = busy;
        sout       = 1'b0;
        last       = 1'b0;
        case (state_q)
            SHIFT: begin
                sout = data_bit;
`ifndef PISO_PARITY_EN
                last = (cnt_q == '0);
`endif
            end
`ifdef PISO_PARITY_EN
            PAR: begin
                sout = par_q;
                last = 1'b1;
            end
`endif
            default: ;
        endcase
        load_ready = (state_q == IDLE) || (last && ser_en);
        load_acc   = load_valid && load_ready;
    end

    // NOTE: every signal gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        if (load_acc) begin
            state_d = SHIFT;
            shreg_d = din;
            cnt_d   = CNT_LAST;
`ifdef PISO_PARITY_EN
            par_d   = ^din;
`endif
        end else if (state_q == SHIFT && ser_en) begin
            if (cnt_q != '0) begin
                shreg_d = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                           : {1'b0, shreg_q[WIDTH-1:1]};
                cnt_d   = cnt_q - CW'(1);
            end else begin
`ifdef PISO_PARITY_EN
                state_d = PAR;
`else
                state_d = IDLE;
`endif
            end
        end
`ifdef PISO_PARITY_EN
        else if (state_q == PAR && ser_en) begin
            state_d = IDLE;
        end
`endif
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

endmodule
